// File: rtl/dmem_rsp_merger.sv
// Merges per-lane TileLink D responses into one dcache response (tag, thread mask, per-lane data).
// Each lane buffers its beats in a small FIFO; heads sharing the lowest-lane tag are popped together.
module dmem_rsp_merger #(
  parameter int NUM_LANES = 4,
  parameter int DEPTH     = 4,
  parameter int SRC_WIDTH = 10,
  parameter int TAG_WIDTH = 10
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_LANES-1:0]           in_valid,
  input  logic [3*NUM_LANES-1:0]         in_opcode,
  input  logic [SRC_WIDTH*NUM_LANES-1:0] in_source,
  input  logic [32*NUM_LANES-1:0]        in_data,
  output logic [NUM_LANES-1:0]           in_ready,
  output logic                           out_valid,
  output logic [NUM_LANES-1:0]           out_tmask,
  output logic [TAG_WIDTH-1:0]           out_tag,
  output logic [32*NUM_LANES-1:0]        out_data,
  input  logic                           out_ready,
  output logic [15:0]                    ack_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(NUM_LANES + 1);

  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  logic [TAG_WIDTH-1:0] tag_mem_q  [NUM_LANES][DEPTH];
  logic [31:0]          data_mem_q [NUM_LANES][DEPTH];

  logic [PW-1:0] rd_ptr_q [NUM_LANES];
  logic [PW-1:0] rd_ptr_d [NUM_LANES];
  logic [PW-1:0] wr_ptr_q [NUM_LANES];
  logic [PW-1:0] wr_ptr_d [NUM_LANES];
  logic [CW-1:0] cnt_q    [NUM_LANES];
  logic [CW-1:0] cnt_d    [NUM_LANES];
  logic [15:0]   ack_count_q;
  logic [15:0]   ack_count_d;

  logic [NUM_LANES-1:0] accept;
  logic [NUM_LANES-1:0] push;
  logic [NUM_LANES-1:0] ack_beat;
  logic [NUM_LANES-1:0] pop;
  logic [NUM_LANES-1:0] nonempty;
  logic [TAG_WIDTH-1:0] head_tag  [NUM_LANES];
  logic [31:0]          head_data [NUM_LANES];
  logic [AW-1:0]        ack_beats;
  logic [16:0]          ack_sum;
  logic                 sel_found;
  logic [TAG_WIDTH-1:0] sel_tag;

  // Ready comes only from the registered count, so a full lane stays stalled even in its pop cycle.
  always_comb begin
    nonempty = '0;
    in_ready = '0;
    accept   = '0;
    push     = '0;
    ack_beat = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      nonempty[i]  = (cnt_q[i] != '0);
      in_ready[i]  = (cnt_q[i] != CW'(DEPTH));
      head_tag[i]  = tag_mem_q[i][rd_ptr_q[i]];
      head_data[i] = data_mem_q[i][rd_ptr_q[i]];
      accept[i]    = in_valid[i] & in_ready[i];
      push[i]      = accept[i] & (in_opcode[3*i +: 3] == OP_ACCESS_ACK_DATA);
      ack_beat[i]  = accept[i] & (in_opcode[3*i +: 3] == OP_ACCESS_ACK);
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_tag   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (nonempty[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_tag   = head_tag[i];
      end
    end
  end

  always_comb begin
    out_valid = sel_found;
    out_tag   = sel_tag;
    out_tmask = '0;
    out_data  = '0;
    pop       = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      out_tmask[i] = nonempty[i] && (head_tag[i] == sel_tag);
      if (out_tmask[i]) begin
        out_data[32*i +: 32] = head_data[i];
      end
      pop[i] = sel_found & out_ready & out_tmask[i];
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
      wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
      cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  always_comb begin
    ack_beats = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      ack_beats = ack_beats + AW'(ack_beat[i]);
    end
    ack_sum     = {1'b0, ack_count_q} + 17'(ack_beats);
    ack_count_d = ack_sum[16] ? 16'hFFFF : ack_sum[15:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ack_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      ack_count_q <= ack_count_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (push[i]) begin
        tag_mem_q[i][wr_ptr_q[i]]  <= in_source[SRC_WIDTH*i +: TAG_WIDTH];
        data_mem_q[i][wr_ptr_q[i]] <= in_data[32*i +: 32];
      end
    end
  end

  assign ack_count = ack_count_q;

endmodule
